// File: rtl/hazard_pkg.sv
// Shared constants, state encoding and control bundle for the pipeline hazard controller.
package hazard_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned FWD_W = 2;
  localparam int unsigned RSRC_W = 2;

  localparam logic [FWD_W-1:0] FWD_RD  = 2'b00;
  localparam logic [FWD_W-1:0] FWD_WB  = 2'b01;
  localparam logic [FWD_W-1:0] FWD_MEM = 2'b10;

  localparam logic [RSRC_W-1:0] RESULT_LOAD = 2'b01;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_MD_WAIT = 1'b1
  } state_e;

  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic flush_d;
    logic flush_e;
    logic flush_m;
    logic md_start;
  } ctrl_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle of the hazard controller: register ids, enables and control returns.
interface hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  import hazard_pkg::*;

  logic [REG_W-1:0]  Rs1D;
  logic [REG_W-1:0]  Rs2D;
  logic [REG_W-1:0]  Rs1E;
  logic [REG_W-1:0]  Rs2E;
  logic [REG_W-1:0]  RdE;
  logic [REG_W-1:0]  RdM;
  logic [REG_W-1:0]  RdW;
  logic              RegWriteM;
  logic              RegWriteW;
  logic [RSRC_W-1:0] ResultSrcE;
  logic              PcSrcE;
  logic              MdOpE;
  logic              MdDone;

  logic [FWD_W-1:0]  ForwardAE;
  logic [FWD_W-1:0]  ForwardBE;
  logic              StallF;
  logic              StallD;
  logic              StallE;
  logic              FlushD;
  logic              FlushE;
  logic              FlushM;
  logic              MdStart;
  logic              MdError;
  logic [CNT_W-1:0]  StallCount;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output RegWriteM, RegWriteW, ResultSrcE, PcSrcE, MdOpE, MdDone,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE,
    input  FlushD, FlushE, FlushM, MdStart, MdError, StallCount
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  RegWriteM, RegWriteW, ResultSrcE, PcSrcE, MdOpE, MdDone,
    output ForwardAE, ForwardBE, StallF, StallD, StallE,
    output FlushD, FlushE, FlushM, MdStart, MdError, StallCount
  );

endinterface

// File: rtl/hazard_fwd_sel.sv
// Forward-select for one Execute operand; Memory wins over Writeback and x0 is never forwarded.
module hazard_fwd_sel
  import hazard_pkg::*;
(
  input  logic [REG_W-1:0] rs_e,
  input  logic [REG_W-1:0] rd_m,
  input  logic [REG_W-1:0] rd_w,
  input  logic             reg_write_m,
  input  logic             reg_write_w,
  output logic [FWD_W-1:0] fwd_sel_c
);

  always_comb begin
    fwd_sel_c = FWD_RD;
    if (reg_write_m && (rd_m != '0) && (rd_m == rs_e)) begin
      fwd_sel_c = FWD_MEM;
    end else if (reg_write_w && (rd_w != '0) && (rd_w == rs_e)) begin
      fwd_sel_c = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/sequencing controller: operand forwarding, load-use and branch handling,
// mul/div start/done sequencing with timeout, and a saturating stall-cycle counter.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned MD_TIMEOUT = 64
) (
  input  logic           Clk,
  input  logic           Reset,
  hazard_ctrl_if.slave   bus
);

  localparam int unsigned      TMO_W    = $clog2(MD_TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MD_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e           state;
  state_e           state_nxt;
  logic [TMO_W-1:0] tmo_cnt;
  logic [CNT_W-1:0] stall_count;
  logic             md_error;
  logic             lw_stall_c;
  logic             tmo_hit_c;
  ctrl_t            ctrl_c;
  logic [FWD_W-1:0] fwd_a_c;
  logic [FWD_W-1:0] fwd_b_c;

  hazard_fwd_sel u_fwd_a (
    .rs_e        (bus.Rs1E),
    .rd_m        (bus.RdM),
    .rd_w        (bus.RdW),
    .reg_write_m (bus.RegWriteM),
    .reg_write_w (bus.RegWriteW),
    .fwd_sel_c   (fwd_a_c)
  );

  hazard_fwd_sel u_fwd_b (
    .rs_e        (bus.Rs2E),
    .rd_m        (bus.RdM),
    .rd_w        (bus.RdW),
    .reg_write_m (bus.RegWriteM),
    .reg_write_w (bus.RegWriteW),
    .fwd_sel_c   (fwd_b_c)
  );

  assign lw_stall_c = (bus.ResultSrcE == RESULT_LOAD) && (bus.RdE != '0) &&
                      ((bus.RdE == bus.Rs1D) || (bus.RdE == bus.Rs2D));

  // Last permitted wait cycle elapsed with no result from the unit.
  assign tmo_hit_c = (state == ST_MD_WAIT) && !bus.MdDone && (tmo_cnt == TMO_LAST);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_RUN:     if (bus.MdOpE) state_nxt = ST_MD_WAIT;
      ST_MD_WAIT: if (bus.MdDone || tmo_hit_c) state_nxt = ST_RUN;
      default:    state_nxt = ST_RUN;
    endcase
  end

  // Stall/flush/start decode; a mul/div in E overrides load-use and branch handling.
  always_comb begin
    ctrl_c = '0;
    if (Reset) begin
      ctrl_c.flush_d = 1'b1;
      ctrl_c.flush_e = 1'b1;
      ctrl_c.flush_m = 1'b1;
    end else begin
      unique case (state)
        ST_RUN: begin
          if (bus.MdOpE) begin
            ctrl_c.stall_f  = 1'b1;
            ctrl_c.stall_d  = 1'b1;
            ctrl_c.stall_e  = 1'b1;
            ctrl_c.flush_m  = 1'b1;
            ctrl_c.md_start = 1'b1;
          end else begin
            ctrl_c.stall_f = lw_stall_c;
            ctrl_c.stall_d = lw_stall_c;
            ctrl_c.flush_d = bus.PcSrcE;
            ctrl_c.flush_e = lw_stall_c | bus.PcSrcE;
          end
        end
        ST_MD_WAIT: begin
          if (tmo_hit_c) begin
            ctrl_c.flush_e = 1'b1;
          end else if (!bus.MdDone) begin
            ctrl_c.stall_f = 1'b1;
            ctrl_c.stall_d = 1'b1;
            ctrl_c.stall_e = 1'b1;
            ctrl_c.flush_m = 1'b1;
          end
        end
        default: ctrl_c = '0;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      tmo_cnt     <= '0;
      stall_count <= '0;
      md_error    <= 1'b0;
    end else begin
      if ((state == ST_MD_WAIT) && !bus.MdDone && !tmo_hit_c) begin
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      end else begin
        tmo_cnt <= '0;
      end
      if (ctrl_c.stall_f && (stall_count != CNT_MAX)) begin
        stall_count <= stall_count + CNT_W'(1);
      end
      if (tmo_hit_c) begin
        md_error <= 1'b1;
      end
    end
  end

  assign bus.ForwardAE  = fwd_a_c;
  assign bus.ForwardBE  = fwd_b_c;
  assign bus.StallF     = ctrl_c.stall_f;
  assign bus.StallD     = ctrl_c.stall_d;
  assign bus.StallE     = ctrl_c.stall_e;
  assign bus.FlushD     = ctrl_c.flush_d;
  assign bus.FlushE     = ctrl_c.flush_e;
  assign bus.FlushM     = ctrl_c.flush_m;
  assign bus.MdStart    = ctrl_c.md_start;
  assign bus.MdError    = md_error;
  assign bus.StallCount = stall_count;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: a default-parameter instance and a small one (CNT_W=3, MD_TIMEOUT=4).
module tb_hazard_ctrl;
  import hazard_pkg::*;

  typedef struct packed {
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic       rwm, rww;
    logic [1:0] rse;
    logic       pc, md, done, rst;
  } in_t;

  typedef struct packed {
    logic [1:0] fa, fb;
    logic       sf, sd, se, fd, fe, fm, ms;
    logic       to;
  } exp_t;

  typedef struct {
    string nm;
    int    sel;
    in_t   vin;
    exp_t  vex;
  } vec_t;

  typedef struct {
    string       nm;
    int          sel;
    exp_t        ex;
    int unsigned cnt;
    logic        err;
  } sb_t;

  // {sf sd se fd fe fm ms}
  localparam logic [6:0] C_IDLE  = 7'b000_000_0;
  localparam logic [6:0] C_RST   = 7'b000_111_0;
  localparam logic [6:0] C_LOAD  = 7'b110_010_0;
  localparam logic [6:0] C_BR    = 7'b000_110_0;
  localparam logic [6:0] C_LDBR  = 7'b110_110_0;
  localparam logic [6:0] C_MDGO  = 7'b111_001_1;
  localparam logic [6:0] C_MDWT  = 7'b111_001_0;
  localparam logic [6:0] C_TMO   = 7'b000_010_0;
  localparam int unsigned MAX_A  = 65535;
  localparam int unsigned MAX_B  = 7;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(16)) bus_a ();
  hazard_ctrl_if #(.CNT_W(3))  bus_b ();

  hazard_ctrl #(.CNT_W(16), .MD_TIMEOUT(64)) dut_a (.Clk(clk), .Reset(rst), .bus(bus_a.slave));
  hazard_ctrl #(.CNT_W(3),  .MD_TIMEOUT(4))  dut_b (.Clk(clk), .Reset(rst), .bus(bus_b.slave));

  sb_t         sbq[$];
  vec_t        tbl[$];
  int          n_chk  = 0;
  int          n_pass = 0;
  int unsigned cnt_a  = 0;
  int unsigned cnt_b  = 0;
  logic        err_a  = 1'b0;
  logic        err_b  = 1'b0;

  function automatic in_t mki(int rs1d, int rs2d, int rs1e, int rs2e, int rde, int rdm, int rdw,
                              int rwm, int rww, int rse, int pc, int md, int done, int r);
    in_t i;
    i.rs1d = 5'(rs1d); i.rs2d = 5'(rs2d); i.rs1e = 5'(rs1e); i.rs2e = 5'(rs2e);
    i.rde  = 5'(rde);  i.rdm  = 5'(rdm);  i.rdw  = 5'(rdw);
    i.rwm  = 1'(rwm);  i.rww  = 1'(rww);  i.rse  = 2'(rse);
    i.pc   = 1'(pc);   i.md   = 1'(md);   i.done = 1'(done); i.rst = 1'(r);
    return i;
  endfunction

  function automatic exp_t mkx(logic [1:0] fa, logic [1:0] fb, logic [6:0] sc, logic to);
    exp_t e;
    e.fa = fa; e.fb = fb;
    {e.sf, e.sd, e.se, e.fd, e.fe, e.fm, e.ms} = sc;
    e.to = to;
    return e;
  endfunction

  task automatic drive(input in_t i);
    rst = i.rst;
    bus_a.Rs1D = i.rs1d; bus_a.Rs2D = i.rs2d; bus_a.Rs1E = i.rs1e; bus_a.Rs2E = i.rs2e;
    bus_a.RdE = i.rde; bus_a.RdM = i.rdm; bus_a.RdW = i.rdw;
    bus_a.RegWriteM = i.rwm; bus_a.RegWriteW = i.rww; bus_a.ResultSrcE = i.rse;
    bus_a.PcSrcE = i.pc; bus_a.MdOpE = i.md; bus_a.MdDone = i.done;
    bus_b.Rs1D = i.rs1d; bus_b.Rs2D = i.rs2d; bus_b.Rs1E = i.rs1e; bus_b.Rs2E = i.rs2e;
    bus_b.RdE = i.rde; bus_b.RdM = i.rdm; bus_b.RdW = i.rdw;
    bus_b.RegWriteM = i.rwm; bus_b.RegWriteW = i.rww; bus_b.ResultSrcE = i.rse;
    bus_b.PcSrcE = i.pc; bus_b.MdOpE = i.md; bus_b.MdDone = i.done;
  endtask

  task automatic check();
    sb_t        s;
    logic [10:0] act;
    logic [10:0] want;
    logic [15:0] acnt;
    logic        aerr;
    s = sbq.pop_front();
    if (s.sel == 0) begin
      act  = {bus_a.ForwardAE, bus_a.ForwardBE, bus_a.StallF, bus_a.StallD, bus_a.StallE,
              bus_a.FlushD, bus_a.FlushE, bus_a.FlushM, bus_a.MdStart};
      acnt = bus_a.StallCount;
      aerr = bus_a.MdError;
    end else begin
      act  = {bus_b.ForwardAE, bus_b.ForwardBE, bus_b.StallF, bus_b.StallD, bus_b.StallE,
              bus_b.FlushD, bus_b.FlushE, bus_b.FlushM, bus_b.MdStart};
      acnt = 16'(bus_b.StallCount);
      aerr = bus_b.MdError;
    end
    want = {s.ex.fa, s.ex.fb, s.ex.sf, s.ex.sd, s.ex.se, s.ex.fd, s.ex.fe, s.ex.fm, s.ex.ms};
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s ctrl: got %b want %b (fa fb sf sd se fd fe fm ms)", s.nm, act, want);
    n_chk++;
    if (acnt === 16'(s.cnt)) n_pass++;
    else $display("FAIL %s StallCount: got %0d want %0d", s.nm, acnt, s.cnt);
    n_chk++;
    if (aerr === s.err) n_pass++;
    else $display("FAIL %s MdError: got %b want %b", s.nm, aerr, s.err);
  endtask

  // Drive one cycle, record the expectation, compare mid-cycle, then advance the model.
  task automatic step(input string nm, input int sel, input in_t i, input exp_t e);
    sb_t s;
    drive(i);
    s.nm  = nm;
    s.sel = sel;
    s.ex  = e;
    s.cnt = (sel == 0) ? cnt_a : cnt_b;
    s.err = (sel == 0) ? err_a : err_b;
    sbq.push_back(s);
    @(negedge clk);
    check();
    if (i.rst) begin
      cnt_a = 0; cnt_b = 0; err_a = 1'b0; err_b = 1'b0;
    end else if (sel == 0) begin
      if (e.sf && cnt_a < MAX_A) cnt_a++;
      err_a = err_a | e.to;
    end else begin
      if (e.sf && cnt_b < MAX_B) cnt_b++;
      err_b = err_b | e.to;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic add(input string nm, input in_t i, input exp_t e);
    vec_t v;
    v.nm = nm; v.sel = 0; v.vin = i; v.vex = e;
    tbl.push_back(v);
  endtask

  initial begin
    // Single-cycle vectors on the default instance.
    //               rs1d rs2d rs1e rs2e rde rdm rdw rwm rww rse pc md dn rst
    add("reset",     mki(0, 0, 5, 0, 0, 5, 0, 1, 0, 0, 1, 1, 0, 1), mkx(FWD_MEM, FWD_RD,  C_RST,  1'b0));
    add("fwd_mem",   mki(0, 0, 5, 0, 0, 5, 5, 1, 1, 0, 0, 0, 0, 0), mkx(FWD_MEM, FWD_RD,  C_IDLE, 1'b0));
    add("fwd_wb",    mki(0, 0, 5, 0, 0, 5, 5, 0, 1, 0, 0, 0, 0, 0), mkx(FWD_WB,  FWD_RD,  C_IDLE, 1'b0));
    add("fwd_x0",    mki(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0), mkx(FWD_RD,  FWD_RD,  C_IDLE, 1'b0));
    add("fwd_b_mem", mki(0, 0, 0, 9, 0, 9, 9, 1, 1, 0, 0, 0, 0, 0), mkx(FWD_RD,  FWD_MEM, C_IDLE, 1'b0));
    add("fwd_mix",   mki(0, 0, 4, 3, 0, 4, 3, 1, 1, 0, 0, 0, 0, 0), mkx(FWD_MEM, FWD_WB,  C_IDLE, 1'b0));
    add("fwd_nowe",  mki(0, 0, 4, 3, 0, 4, 3, 0, 0, 0, 0, 0, 0, 0), mkx(FWD_RD,  FWD_RD,  C_IDLE, 1'b0));
    add("load_use",  mki(0, 7, 0, 0, 7, 0, 0, 0, 0, 1, 0, 0, 0, 0), mkx(FWD_RD,  FWD_RD,  C_LOAD, 1'b0));
    add("not_load",  mki(0, 7, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0), mkx(FWD_RD,  FWD_RD,  C_IDLE, 1'b0));
    add("load_rd0",  mki(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), mkx(FWD_RD,  FWD_RD,  C_IDLE, 1'b0));
    add("branch",    mki(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), mkx(FWD_RD,  FWD_RD,  C_BR,   1'b0));
    add("load_br",   mki(3, 0, 0, 0, 3, 0, 0, 0, 0, 1, 1, 0, 0, 0), mkx(FWD_RD,  FWD_RD,  C_LDBR, 1'b0));
    add("load_rs1",  mki(12, 0, 0, 0, 12, 0, 0, 0, 0, 1, 0, 0, 0, 0), mkx(FWD_RD, FWD_RD,  C_LOAD, 1'b0));
    add("alu_rs1",   mki(12, 0, 0, 0, 12, 0, 0, 0, 0, 2, 0, 0, 0, 0), mkx(FWD_RD, FWD_RD,  C_IDLE, 1'b0));
    add("done_run",  mki(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), mkx(FWD_RD,  FWD_RD,  C_IDLE, 1'b0));

    drive(mki(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    @(posedge clk);
    #1;

    for (int k = 0; k < tbl.size(); k++) step(tbl[k].nm, tbl[k].sel, tbl[k].vin, tbl[k].vex);

    // Mul/div: start with a competing load-use and branch, done five cycles later.
    step("md_go", 0, mki(0, 7, 0, 0, 7, 0, 0, 0, 0, 1, 1, 1, 0, 0), mkx(FWD_RD, FWD_RD, C_MDGO, 1'b0));
    for (int k = 0; k < 4; k++)
      step("md_wait", 0, mki(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), mkx(FWD_RD, FWD_RD, C_MDWT, 1'b0));
    step("md_done", 0, mki(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), mkx(FWD_RD, FWD_RD, C_IDLE, 1'b0));
    step("md_after", 0, mki(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), mkx(FWD_RD, FWD_RD, C_IDLE, 1'b0));
    step("md_stray", 0, mki(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), mkx(FWD_RD, FWD_RD, C_IDLE, 1'b0));
    step("rst_a", 0, mki(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), mkx(FWD_RD, FWD_RD, C_RST, 1'b0));

    // Timeout on the small instance: no done ever arrives.
    step("tmo_go", 1, mki(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), mkx(FWD_RD, FWD_RD, C_MDGO, 1'b0));
    for (int k = 0; k < 3; k++)
      step("tmo_wait", 1, mki(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), mkx(FWD_RD, FWD_RD, C_MDWT, 1'b0));
    step("tmo_hit", 1, mki(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), mkx(FWD_RD, FWD_RD, C_TMO, 1'b1));
    step("tmo_run", 1, mki(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), mkx(FWD_RD, FWD_RD, C_IDLE, 1'b0));
    step("tmo_late", 1, mki(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), mkx(FWD_RD, FWD_RD, C_IDLE, 1'b0));
    step("tmo_rst", 1, mki(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), mkx(FWD_RD, FWD_RD, C_RST, 1'b0));
    step("tmo_clr", 1, mki(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), mkx(FWD_RD, FWD_RD, C_IDLE, 1'b0));

    // Reset in the second wait cycle returns to RUN; the late done is ignored.
    step("rm_go", 0, mki(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), mkx(FWD_RD, FWD_RD, C_MDGO, 1'b0));
    step("rm_wait", 0, mki(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), mkx(FWD_RD, FWD_RD, C_MDWT, 1'b0));
    step("rm_rst", 0, mki(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), mkx(FWD_RD, FWD_RD, C_RST, 1'b0));
    step("rm_run", 0, mki(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), mkx(FWD_RD, FWD_RD, C_BR, 1'b0));
    step("rm_late", 0, mki(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), mkx(FWD_RD, FWD_RD, C_IDLE, 1'b0));

    // Continuous load-use stall saturates the 3-bit counter at 7.
    step("sat_rst", 0, mki(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), mkx(FWD_RD, FWD_RD, C_RST, 1'b0));
    for (int k = 0; k < 10; k++)
      step("sat_stall", 1, mki(0, 7, 0, 0, 7, 0, 0, 0, 0, 1, 0, 0, 0, 0), mkx(FWD_RD, FWD_RD, C_LOAD, 1'b0));
    step("sat_end", 1, mki(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), mkx(FWD_RD, FWD_RD, C_IDLE, 1'b0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
